// File: rtl/axi_lite_decoder.sv
// axi_lite_decoder: registered one-hot slave select for the AXI-Lite AW and AR channels.
// The top REGION_BITS of each address pick the slave; indices >= NUM_SLAVES decode to zero (DECERR).
module axi_lite_decoder #(
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int REGION_BITS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] i_axi_awaddr,
    input  logic [ADDR_WIDTH-1:0] i_axi_araddr,
    output logic [NUM_SLAVES-1:0] o_slave_select_write,
    output logic [NUM_SLAVES-1:0] o_slave_select_read
);

    logic [REGION_BITS-1:0] idx_w, idx_r;
    logic [NUM_SLAVES-1:0]  next_w, next_r;

    assign idx_w = i_axi_awaddr[ADDR_WIDTH-1 -: REGION_BITS];
    assign idx_r = i_axi_araddr[ADDR_WIDTH-1 -: REGION_BITS];

    // Only indices below NUM_SLAVES have a matching bit, so out-of-range indices fall out as all-zero.
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_sel
        assign next_w[g] = idx_w == REGION_BITS'(g);
        assign next_r[g] = idx_r == REGION_BITS'(g);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_slave_select_write <= '0;
            o_slave_select_read  <= '0;
        end else begin
            o_slave_select_write <= next_w;
            o_slave_select_read  <= next_r;
        end
    end

endmodule

// File: tb/tb_axi_lite_decoder.sv
// tb_axi_lite_decoder: directed checks of reset, region decode, boundaries, latency and mid-run reset.
module tb_axi_lite_decoder;

    logic        clk;
    logic        resetn;
    logic [31:0] awaddr;
    logic [31:0] araddr;
    logic [2:0]  sel_w;
    logic [2:0]  sel_r;
    int          tests;
    int          fails;

    logic [31:0] b2b_addr [4];
    logic [2:0]  b2b_exp  [4];
    logic [2:0]  prev_r;

    axi_lite_decoder dut (
        .clk                  (clk),
        .resetn               (resetn),
        .i_axi_awaddr         (awaddr),
        .i_axi_araddr         (araddr),
        .o_slave_select_write (sel_w),
        .o_slave_select_read  (sel_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] aw, input logic [31:0] ar);
        @(negedge clk);
        awaddr = aw;
        araddr = ar;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        resetn = 1'b1;
        awaddr = 'x;
        araddr = 'x;
        b2b_addr = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
        b2b_exp  = '{3'b001, 3'b010, 3'b100, 3'b000};

        #10 resetn = 1'b0;
        #2;
        chk("reset_w", sel_w, 3'b000);
        chk("reset_r", sel_r, 3'b000);
        #6;
        chk("reset_hold_w", sel_w, 3'b000);
        chk("reset_hold_r", sel_r, 3'b000);
        #2 resetn = 1'b1;
        #1;
        chk("release_no_edge_w", sel_w, 3'b000);
        chk("release_no_edge_r", sel_r, 3'b000);

        #79;
        awaddr = 32'h0111_1111;
        araddr = 32'h0211_1111;
        #1;
        tests++;
        assert (sel_w !== 3'b010 && sel_r !== 3'b100) else begin
            fails++;
            $error("FAIL basic_early: observed w=%b r=%b before the clock edge, expected no decode yet", sel_w, sel_r);
        end
        @(posedge clk);
        #1;
        chk("basic_w", sel_w, 3'b010);
        chk("basic_r", sel_r, 3'b100);

        step(32'h0000_0000, 32'h0100_0000);
        chk("bound_w_0", sel_w, 3'b001);
        chk("bound_r_1", sel_r, 3'b010);
        step(32'h00FF_FFFF, 32'h00FF_FFFF);
        chk("bound_w_00ffffff", sel_w, 3'b001);
        chk("bound_r_00ffffff", sel_r, 3'b001);
        step(32'h0100_0000, 32'h01FF_FFFF);
        chk("bound_w_01000000", sel_w, 3'b010);
        chk("bound_r_01ffffff", sel_r, 3'b010);
        step(32'h02FF_FFFF, 32'h0200_0000);
        chk("bound_w_02ffffff", sel_w, 3'b100);
        chk("bound_r_02000000", sel_r, 3'b100);

        step(32'h0300_0000, 32'hFFFF_FFFF);
        chk("unmapped_w", sel_w, 3'b000);
        chk("unmapped_r", sel_r, 3'b000);
        step(32'h8012_3456, 32'h0400_0000);
        chk("unmapped_w_high", sel_w, 3'b000);
        chk("unmapped_r_04", sel_r, 3'b000);

        step(32'h0100_0000, 32'h0200_0000);
        chk("b2b_pre_w", sel_w, 3'b010);
        prev_r = 3'b100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            araddr = b2b_addr[i];
            #1;
            chk("b2b_before_edge", sel_r, prev_r);
            @(posedge clk);
            #1;
            chk("b2b_r", sel_r, b2b_exp[i]);
            chk("b2b_w_stable", sel_w, 3'b010);
            prev_r = b2b_exp[i];
        end

        step(32'h0111_1111, 32'h0211_1111);
        chk("mid_pre_w", sel_w, 3'b010);
        chk("mid_pre_r", sel_r, 3'b100);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("mid_reset_w", sel_w, 3'b000);
        chk("mid_reset_r", sel_r, 3'b000);
        #1 resetn = 1'b1;
        #1;
        chk("mid_release_w", sel_w, 3'b000);
        chk("mid_release_r", sel_r, 3'b000);
        @(posedge clk);
        #1;
        chk("mid_resume_w", sel_w, 3'b010);
        chk("mid_resume_r", sel_r, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_decoder.md
Name: axi_lite_decoder

Overview:
- Address decoder for the AXI-Lite interconnect.
- Maps the write address (AW channel) and read address (AR channel) independently onto one-hot slave-select vectors.
- The interconnect's write and read routing muxes use these vectors.
- Outputs are registered on the single clock, giving one cycle of latency.

Parameters:
- NUM_SLAVES, default 3: number of slave regions; width of each select vector; legal range 1..256.
- ADDR_WIDTH, default 32: width of both address inputs; minimum 9.
- REGION_BITS, default 8: number of address MSBs forming the region index; must be at least ceil(log2(NUM_SLAVES)) and less than ADDR_WIDTH.

Ports:
- clk  input  1: system clock, rising edge.
- resetn  input  1: asynchronous active-low reset.
- i_axi_awaddr  input  ADDR_WIDTH: write address to decode.
- i_axi_araddr  input  ADDR_WIDTH: read address to decode.
- o_slave_select_write  output  NUM_SLAVES: one-hot write-slave select, registered.
- o_slave_select_read  output  NUM_SLAVES: one-hot read-slave select, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset (resetn) is asynchronous and active-low.
- Reset state: while resetn = 0, both outputs are all zeros immediately, with no clock edge required.
  - Deassertion is synchronous to the next rising clk edge.
  - The first decode appears at the first rising edge after resetn = 1.
- Region index:
  - Write index idx_w = i_axi_awaddr[ADDR_WIDTH-1 : ADDR_WIDTH-REGION_BITS].
  - Read index idx_r = i_axi_araddr[ADDR_WIDTH-1 : ADDR_WIDTH-REGION_BITS].
  - With the defaults, the index is bits [31:24]. Each slave therefore owns a 16 MiB window:
    - slave 0 at 0x0000_0000–0x00FF_FFFF
    - slave 1 at 0x0100_0000–0x01FF_FFFF
    - slave 2 at 0x0200_0000–0x02FF_FFFF
- Decode rule, applied independently per channel:
  - If idx < NUM_SLAVES, the next select is one-hot with bit idx set.
  - Otherwise the next select is all zeros (unmapped; the interconnect responds DECERR).
- Lower address bits [ADDR_WIDTH-REGION_BITS-1:0] never affect the decode.
- Timing:
  - On every rising clk edge with resetn = 1, each output register loads the decode of its current address.
  - Latency is exactly 1 cycle from address change to output change.
  - There is no hold or enable; an output follows its address every cycle.
- Channel independence: write and read decode in parallel with no interaction. Simultaneous different or identical addresses are legal, and each channel selects on its own.
- Output invariant: each output is always zero-hot or one-hot, never more than one bit set.
- Unknown inputs: if an address input is X/Z, that channel's output is don't-care. It must become valid one cycle after the address is driven.
- Reset mid-operation: asserting resetn forces both outputs to 0 asynchronously. Decoding resumes at the first edge after release using the current addresses.
- Structure: no combinational path from input to output; the outputs are driven directly by flops.

Test Plan:
- Reset, then hold: resetn 1→0 at 10 ns, 0→1 at 20 ns, addresses undriven → both outputs 3'b000 during reset; no X-to-1 glitch while resetn = 0.
- Basic decode: at 100 ns drive i_axi_awaddr = 0x0111_1111 and i_axi_araddr = 0x0211_1111 → o_slave_select_write = 3'b010 and o_slave_select_read = 3'b100 at the first rising edge after 100 ns, not before.
- Region boundaries: awaddr 0x0000_0000 → 3'b001; 0x00FF_FFFF → 3'b001; 0x0100_0000 → 3'b010; 0x02FF_FFFF → 3'b100.
- Unmapped region: awaddr 0x0300_0000 → 3'b000; araddr 0xFFFF_FFFF → 3'b000.
- Back-to-back: change araddr every cycle through 0x0000_0000, 0x0100_0000, 0x0200_0000, 0x0300_0000 → read select is 001, 010, 100, 000, each exactly one cycle delayed. Write channel is unaffected throughout.
- Reset mid-operation: with both outputs non-zero, pulse resetn low between edges → outputs go to 3'b000 immediately. After release, decode of the held addresses reappears at the next rising edge.
